// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared state encoding and UART motion command layout for drive_ctrl
package drive_pkg;

  typedef enum logic [2:0] {
    ST_POWER_OFF    = 3'd0,
    ST_POWER_ON     = 3'd1,
    ST_NOT_STARTING = 3'd2,
    ST_STARTING     = 3'd3,
    ST_MOVING       = 3'd4
  } state_e;

  localparam logic [1:0] CMD_HDR = 2'b10;

  localparam int CMD_FWD     = 0;
  localparam int CMD_BWD     = 1;
  localparam int CMD_LEFT    = 2;
  localparam int CMD_RIGHT   = 3;
  localparam int CMD_PLACE   = 4;
  localparam int CMD_DESTROY = 5;

  localparam logic [7:0] CMD_IDLE = {CMD_HDR, 6'b000000};

  function automatic logic [7:0] move_cmd(input logic destroy, input logic place,
                                          input logic right, input logic left,
                                          input logic reverse);
    logic [7:0] c;
    c              = CMD_IDLE;
    c[CMD_FWD]     = ~reverse;
    c[CMD_BWD]     = reverse;
    c[CMD_LEFT]    = left;
    c[CMD_RIGHT]   = right;
    c[CMD_PLACE]   = place;
    c[CMD_DESTROY] = destroy;
    return c;
  endfunction

  // Bits needed to count 0..n-1; a 1-cycle period still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - enabled modulo counter that pulses wrap_o on the cycle it rolls over
module tick_divider #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TERMINAL = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_q, count_d;

  // wrap_o is combinational so the consumer registers its update on the same edge
  always_comb begin
    wrap_o  = en_i && (count_q == TERM);
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/drive_ctrl.sv
// rtl/drive_ctrl.sv - manual-drive power/start/move FSM with UART command, mileage and turn LEDs
import drive_pkg::*;

module drive_ctrl #(
  parameter int unsigned POWER_ON_HOLD_CYC = 100_000_000,
  parameter int unsigned TICKS_PER_UNIT    = 100_000_000,
  parameter int unsigned BLINK_HALF_CYC    = 50_000_000,
  parameter int unsigned MILEAGE_W         = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 power_on_signal,
  input  logic                 power_off_signal,
  input  logic                 manual_driving_signal,
  input  logic                 throttle_signal,
  input  logic                 clutch_signal,
  input  logic                 brake_signal,
  input  logic                 reverse_signal,
  input  logic                 turn_left_signal,
  input  logic                 turn_right_signal,
  input  logic                 place_barrier_signal,
  input  logic                 destroy_barrier_signal,
  output logic [2:0]           state_o,
  output logic [7:0]           cmd_o,
  output logic [MILEAGE_W-1:0] mileage_o,
  output logic                 left_turn_led,
  output logic                 right_turn_led,
  output logic                 reverse_led
);

  localparam int unsigned     HOLD_W    = cnt_width(POWER_ON_HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POWER_ON_HOLD_CYC - 1);

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   reverse_q;
  logic [7:0]             cmd_q, cmd_d;
  logic [MILEAGE_W-1:0]   mileage_q, mileage_d;
  logic                   phase_q, phase_d;
  logic                   left_led_q, left_led_d;
  logic                   right_led_q, right_led_d;
  logic                   rev_led_q, rev_led_d;

  logic moving, hold_done, gear_change, unit_tick, blink_tick;

  assign moving      = (state_q == ST_MOVING);
  assign hold_done   = power_on_signal && (hold_q == HOLD_LAST);
  assign gear_change = reverse_signal ^ reverse_q;

  tick_divider #(
    .WIDTH    (cnt_width(TICKS_PER_UNIT)),
    .TERMINAL (TICKS_PER_UNIT - 1)
  ) u_mileage_div (
    .clk_i  (sys_clk),
    .rst_i  (rst),
    .en_i   (moving),
    .wrap_o (unit_tick)
  );

  tick_divider #(
    .WIDTH    (cnt_width(BLINK_HALF_CYC)),
    .TERMINAL (BLINK_HALF_CYC - 1)
  ) u_blink_div (
    .clk_i  (sys_clk),
    .rst_i  (rst),
    .en_i   (1'b1),
    .wrap_o (blink_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_POWER_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // power_off_signal outranks every transition out of a powered state
  always_comb begin
    state_d = state_q;
    if (power_off_signal && (state_q != ST_POWER_OFF)) begin
      state_d = ST_POWER_OFF;
    end else begin
      case (state_q)
        ST_POWER_OFF: begin
          if (hold_done) state_d = ST_POWER_ON;
        end
        ST_POWER_ON: begin
          if (manual_driving_signal) state_d = ST_NOT_STARTING;
        end
        ST_NOT_STARTING: begin
          if ({throttle_signal, brake_signal, clutch_signal} == 3'b101) begin
            state_d = ST_STARTING;
          end else if ({throttle_signal, brake_signal, clutch_signal} == 3'b100) begin
            state_d = ST_POWER_OFF;
          end
        end
        ST_STARTING: begin
          if (brake_signal) begin
            state_d = ST_NOT_STARTING;
          end else if (throttle_signal && !clutch_signal) begin
            state_d = ST_MOVING;
          end
        end
        ST_MOVING: begin
          if (gear_change && !clutch_signal) begin
            state_d = ST_POWER_OFF;
          end else if (brake_signal) begin
            state_d = ST_NOT_STARTING;
          end else if (!throttle_signal || clutch_signal) begin
            state_d = ST_STARTING;
          end
        end
        default: state_d = ST_POWER_OFF;
      endcase
    end
  end

  // LEDs follow the post-edge state and phase so they line up with state_o
  always_comb begin
    hold_d = '0;
    if ((state_q == ST_POWER_OFF) && power_on_signal && !hold_done) begin
      hold_d = hold_q + 1'b1;
    end
    cmd_d       = moving ? move_cmd(destroy_barrier_signal, place_barrier_signal,
                                    turn_right_signal, turn_left_signal, reverse_signal)
                         : CMD_IDLE;
    mileage_d   = mileage_q + {{(MILEAGE_W-1){1'b0}}, unit_tick};
    phase_d     = phase_q ^ blink_tick;
    left_led_d  = turn_left_signal  && phase_d && (state_d != ST_POWER_OFF);
    right_led_d = turn_right_signal && phase_d && (state_d != ST_POWER_OFF);
    rev_led_d   = reverse_signal && (state_d != ST_POWER_OFF);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      hold_q      <= '0;
      reverse_q   <= 1'b0;
      cmd_q       <= CMD_IDLE;
      mileage_q   <= '0;
      phase_q     <= 1'b0;
      left_led_q  <= 1'b0;
      right_led_q <= 1'b0;
      rev_led_q   <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      reverse_q   <= reverse_signal;
      cmd_q       <= cmd_d;
      mileage_q   <= mileage_d;
      phase_q     <= phase_d;
      left_led_q  <= left_led_d;
      right_led_q <= right_led_d;
      rev_led_q   <= rev_led_d;
    end
  end

  assign state_o        = state_q;
  assign cmd_o          = cmd_q;
  assign mileage_o      = mileage_q;
  assign left_turn_led  = left_led_q;
  assign right_turn_led = right_led_q;
  assign reverse_led    = rev_led_q;

endmodule

// File: doc/drive_ctrl.md
# drive_ctrl

Parametrised manual-drive controller for the simulated car. It is the next generation of the top-level driving state machine. It runs the power/start/move state machine, produces the 8-bit UART motion command, and keeps a mileage count. It also drives blinking turn LEDs and a configurable power-on hold time. It sits between the board switch/button inputs and the UART transmitter and seven-segment display.

## Interface
Parameters:
- POWER_ON_HOLD_CYC, 100_000_000: consecutive cycles power_on_signal must be high to power on (≥1).
- TICKS_PER_UNIT, 100_000_000: MOVING cycles per mileage unit (≥1).
- BLINK_HALF_CYC, 50_000_000: turn-LED half period in cycles (≥1).
- MILEAGE_W, 16: mileage counter width.

Ports:
- sys_clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- power_on_signal, power_off_signal, manual_driving_signal  in  1 each  mode controls.
- throttle_signal, clutch_signal, brake_signal, reverse_signal  in  1 each  pedal/gear controls.
- turn_left_signal, turn_right_signal, place_barrier_signal, destroy_barrier_signal  in  1 each  pass-through controls.
- state_o  out  3  current state encoding.
- cmd_o  out  8  {2'b10, destroy, place, right, left, backward, forward}.
- mileage_o  out  MILEAGE_W  distance units travelled.
- left_turn_led, right_turn_led, reverse_led  out  1 each.

All inputs are synchronous to sys_clk and debounced upstream.

## Operation
- States: POWER_OFF=0, POWER_ON=1, NOT_STARTING=2, STARTING=3, MOVING=4. Codes 5–7 are illegal and go to POWER_OFF.
- Global rule: power_off_signal=1 in any state other than POWER_OFF forces POWER_OFF. This has priority over every other rule.
- POWER_OFF:
  - Hold counter increments while power_on_signal=1 and clears when it is 0.
  - When the counter reaches POWER_ON_HOLD_CYC-1 with the input still high, go to POWER_ON.
  - The counter is cleared whenever the state is not POWER_OFF.
- POWER_ON: manual_driving_signal=1 → NOT_STARTING.
- NOT_STARTING, with {throttle, brake, clutch}:
  - 101 → STARTING.
  - 100 → POWER_OFF (stall).
  - otherwise stay.
- STARTING:
  - brake=1 → NOT_STARTING.
  - 100 → MOVING.
  - otherwise stay.
- MOVING:
  - If reverse_signal differs from its previous-cycle sample reverse_q and clutch=0 → POWER_OFF (gear crash).
  - Else brake=1 → NOT_STARTING.
  - Else throttle=0 or clutch=1 → STARTING.
  - Else stay.
- cmd_o:
  - Current state MOVING: next value is {2'b10, destroy, place, right, left, reverse, ~reverse}.
  - Any other state: next value is 8'h80.
- Mileage:
  - Prescaler counts only while state is MOVING. At TICKS_PER_UNIT-1 it wraps to 0 and mileage_o increments.
  - mileage_o wraps modulo 2^MILEAGE_W.
  - The prescaler holds its value (does not clear) outside MOVING.
  - Mileage persists through POWER_OFF; only rst clears it.
- Turn LEDs:
  - A free-running blink phase toggles every BLINK_HALF_CYC cycles.
  - left_turn_led = turn_left_signal & phase & (state≠POWER_OFF). Right is symmetric.
  - Both inputs high makes both LEDs blink in phase (hazard).
- reverse_led = reverse_signal & (state≠POWER_OFF).

## Timing
- All outputs are registered.
- Reset values: state_o=0, cmd_o=8'h80, mileage_o=0, all LEDs 0, hold/prescaler/blink counters 0, phase 0, reverse_q 0.
- Inputs sampled at edge N update state_o at edge N. cmd_o reflects the state of the cycle before, so it lags state_o by 1 cycle.
- Power-on: power_on_signal rising before edge 1 and held gives state_o=POWER_ON after edge POWER_ON_HOLD_CYC. A single low cycle restarts the count.
- Gear crash is detected on the same edge that samples the reverse change. reverse_q updates every cycle in every state.
- Mileage increments on the edge ending the TICKS_PER_UNIT-th MOVING cycle, counted cumulatively.
- rst mid-operation: all registers take reset values at that edge. rst dominates every other input.

## Structure
- Shared package drive_pkg holds:
  - state enum/localparams.
  - CMD_HDR=2'b10.
  - cmd bit indices (FWD=0, BWD=1, LEFT=2, RIGHT=3, PLACE=4, DESTROY=5).
- Sub-module tick_divider(#WIDTH, #TERMINAL) has an enable input and a wrap-pulse output. It is instantiated for the mileage prescaler (enable = MOVING) and for the blink phase (enable = 1).

## Test plan
Parameters POWER_ON_HOLD_CYC=4, TICKS_PER_UNIT=3, BLINK_HALF_CYC=2, MILEAGE_W=4.
- Power-on hold:
  - power_on_signal high 3 cycles, low 1, then high 4 → state_o stays 0 until the 4th high cycle, then 1.
- Start sequence:
  - manual_driving_signal, then {thr,brk,clu}=101, then 100 → states 2, 3, 4.
  - cmd_o=8'h81 one cycle after state_o=4.
  - reverse_signal=1 with clutch=1 → STARTING, cmd_o=8'h80.
- Gear crash:
  - In MOVING, toggle reverse_signal with clutch=0 → state_o=0 next edge, cmd_o=8'h80 one edge later.
- Mileage wrap:
  - 48 MOVING cycles → mileage_o=0 (16 units wrapped).
  - Then exit to STARTING for 5 cycles and re-enter for 3 → mileage_o=1.
- Blink:
  - turn_left_signal=1 in POWER_ON → left_turn_led pattern 0,0,1,1,0,0,… aligned to phase.
  - In POWER_OFF the LED stays 0.
- Reset mid-move:
  - rst=1 for 1 cycle during MOVING with mileage_o=5 → all outputs at reset values on that edge, including mileage_o=0.
